// File: rtl/axi_wr_slave_pkg.sv
// rtl/axi_wr_slave_pkg.sv - response/burst constants and FSM state type for the AXI write slave
package axi_wr_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef logic [1:0] state_t;

  localparam state_t W_IDLE = 2'd0;
  localparam state_t W_DATA = 2'd1;
  localparam state_t W_RESP = 2'd2;

endpackage

// File: rtl/axi_wr_slave_if.sv
// rtl/axi_wr_slave_if.sv - AXI write-channel bundle (AW, W, B) with master/slave views
interface axi_wr_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_wr_slave_mem.sv
// rtl/axi_wr_slave_mem.sv - word memory with byte-enable write port and registered read port
module axi_wr_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so partial bursts survive an ARESETN pulse.
  always_ff @(posedge ACLK) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - AXI write slave (W_IDLE/W_DATA/W_RESP) into a local word memory
// Define AXI_WR_SLAVE_RANGE_CHECK_EN to return DECERR for beats beyond MEM_DEPTH instead of wrapping.
module axi_wr_slave
  import axi_wr_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi_wr_slave_if.slave         S_AXI,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int LSB    = $clog2(DATA_WIDTH/8);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(MEM_DEPTH);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cnt;
  logic [1:0]       burst;
  logic             err;
  logic             no_wr;
  logic             dec;
  logic [1:0]       bresp_q;

  logic              w_hs;
  logic              last_beat;
  logic              attr_bad;
  logic              in_range;
  logic              err_n;
  logic              dec_n;
  logic [1:0]        resp_n;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [MEM_AW-1:0] mem_raddr;

  assign S_AXI.awready = (state == W_IDLE);
  assign S_AXI.wready  = (state == W_DATA);
  assign S_AXI.bvalid  = (state == W_RESP);
  assign S_AXI.bresp   = bresp_q;

  assign w_hs      = S_AXI.wready && S_AXI.wvalid;
  assign last_beat = (cnt == 8'd0);
  assign attr_bad  = (S_AXI.awsize != 3'(LSB)) ||
                     ((S_AXI.awburst != BURST_FIXED) && (S_AXI.awburst != BURST_INCR));

`ifdef AXI_WR_SLAVE_RANGE_CHECK_EN
  assign in_range = (idx < DEPTH_C);
`else
  assign in_range = 1'b1;
`endif

  // The counter, not wlast, decides the end of burst; a misplaced wlast only flags an error.
  assign err_n  = err || (S_AXI.wlast != last_beat);
  assign dec_n  = dec || !in_range;
  assign resp_n = dec_n ? RESP_DECERR : (err_n ? RESP_SLVERR : RESP_OKAY);

  assign mem_we    = w_hs && !no_wr && in_range;
  assign mem_waddr = MEM_AW'(idx % DEPTH_C);
  assign mem_raddr = MEM_AW'(IDX_W'(dbg_addr >> LSB) % DEPTH_C);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= W_IDLE;
      idx     <= '0;
      cnt     <= '0;
      burst   <= BURST_FIXED;
      err     <= 1'b0;
      no_wr   <= 1'b0;
      dec     <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      case (state)
        W_IDLE: begin
          if (S_AXI.awvalid) begin
            idx   <= IDX_W'(S_AXI.awaddr >> LSB);
            cnt   <= S_AXI.awlen;
            burst <= S_AXI.awburst;
            err   <= attr_bad;
            no_wr <= attr_bad;
            dec   <= 1'b0;
            state <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_AXI.wvalid) begin
            err <= err_n;
            dec <= dec_n;
            if (burst == BURST_INCR) idx <= idx + IDX_W'(1);
            if (last_beat) begin
              state   <= W_RESP;
              bresp_q <= resp_n;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI.bready) begin
            state   <= W_IDLE;
            bresp_q <= RESP_OKAY;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

  axi_wr_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .AW         (MEM_AW)
  ) u_mem (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (S_AXI.wdata),
    .wstrb   (S_AXI.wstrb),
    .raddr   (mem_raddr),
    .rdata   (dbg_rdata)
  );

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb/tb_axi_wr_slave.sv - self-checking bench: vector table, directed corner cases, random bursts vs model
module tb_axi_wr_slave;
  import axi_wr_slave_pkg::*;

  localparam int MEM_DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  axi_wr_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

  axi_wr_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (MEM_DEPTH)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .S_AXI     (s_axi),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] ref_mem   [MEM_DEPTH];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];
  logic        beat_last [256];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        last;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  exp_resp;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst-level model: what each beat does to memory and what the response must be.
  function automatic logic [1:0] model_burst(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
    bit     bad;
    bit     err;
    bit     dec;
    longint w;
    bad = (size != 3'd2) || (burst > 2'd1);
    err = bad;
    dec = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      w = longint'(addr >> 2) + ((burst == BURST_INCR) ? b : 0);
      if (beat_last[b] != (b == int'(len))) err = 1'b1;
`ifdef AXI_WR_SLAVE_RANGE_CHECK_EN
      if (w >= MEM_DEPTH) begin
        dec = 1'b1;
        continue;
      end
`endif
      if (!bad) begin
        for (int k = 0; k < 4; k++)
          if (beat_strb[b][k]) ref_mem[int'(w % MEM_DEPTH)][8*k +: 8] = beat_data[b][8*k +: 8];
      end
    end
    return dec ? RESP_DECERR : (err ? RESP_SLVERR : RESP_OKAY);
  endfunction

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int bdelay, input int gap,
                           input logic [1:0] exp_resp, input string name);
    int k;
    @(negedge ACLK);
    s_axi.awaddr  = addr;
    s_axi.awlen   = len;
    s_axi.awsize  = size;
    s_axi.awburst = burst;
    s_axi.awvalid = 1'b1;
    k = 0;
    while (!s_axi.awready && k < 64) begin @(negedge ACLK); k++; end
    if (!s_axi.awready) begin
      check({name, "_aw_timeout"}, s_axi.awready, 1);
      s_axi.awvalid = 1'b0;
      return;
    end
    @(negedge ACLK);
    s_axi.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gap > 0 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, gap)) @(negedge ACLK);
      s_axi.wdata  = beat_data[b];
      s_axi.wstrb  = beat_strb[b];
      s_axi.wlast  = beat_last[b];
      s_axi.wvalid = 1'b1;
      k = 0;
      while (!s_axi.wready && k < 64) begin @(negedge ACLK); k++; end
      if (!s_axi.wready) begin
        check({name, "_w_timeout"}, s_axi.wready, 1);
        s_axi.wvalid = 1'b0;
        return;
      end
      @(negedge ACLK);
      s_axi.wvalid = 1'b0;
    end
    k = 0;
    while (!s_axi.bvalid && k < 64) begin @(negedge ACLK); k++; end
    if (!s_axi.bvalid) begin
      check({name, "_b_timeout"}, s_axi.bvalid, 1);
      return;
    end
    check({name, "_bresp"}, s_axi.bresp, exp_resp);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge ACLK);
      check({name, "_bvalid_hold"}, s_axi.bvalid, 1);
      check({name, "_bresp_hold"}, s_axi.bresp, exp_resp);
    end
    s_axi.bready = 1'b1;
    @(negedge ACLK);
    s_axi.bready = 1'b0;
    check({name, "_bvalid_drop"}, s_axi.bvalid, 0);
    check({name, "_awready_back"}, s_axi.awready, 1);
  endtask

  task automatic dbg_check(input int word, input logic [31:0] exp, input string name);
    @(negedge ACLK);
    dbg_addr = 32'(word * 4);
    @(negedge ACLK);
    check(name, dbg_rdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          word;
    int          r;

    vecs[0] = '{32'h24, 4'hF, 32'h12345678, 1'b1, 3'd2, BURST_INCR,  RESP_OKAY,   32'h12345678};
    vecs[1] = '{32'h28, 4'h3, 32'hCAFEF00D, 1'b1, 3'd2, BURST_INCR,  RESP_OKAY,   32'h0000F00D};
    vecs[2] = '{32'h2C, 4'h0, 32'hFFFFFFFF, 1'b1, 3'd2, BURST_INCR,  RESP_OKAY,   32'h00000000};
    vecs[3] = '{32'h30, 4'hA, 32'hAABBCCDD, 1'b1, 3'd2, BURST_FIXED, RESP_OKAY,   32'hAA00CC00};
    vecs[4] = '{32'h34, 4'hF, 32'h11111111, 1'b0, 3'd2, BURST_INCR,  RESP_SLVERR, 32'h11111111};
    vecs[5] = '{32'h38, 4'hF, 32'h22222222, 1'b1, 3'd3, BURST_INCR,  RESP_SLVERR, 32'h00000000};
    vecs[6] = '{32'h3C, 4'hF, 32'h33333333, 1'b1, 3'd1, BURST_INCR,  RESP_SLVERR, 32'h00000000};
    vecs[7] = '{32'h40, 4'hF, 32'h44444444, 1'b1, 3'd2, 2'b10,       RESP_SLVERR, 32'h00000000};
    vecs[8] = '{32'h44, 4'hF, 32'h55555555, 1'b1, 3'd2, 2'b11,       RESP_SLVERR, 32'h00000000};
    vecs[9] = '{32'h48, 4'hC, 32'h9ABCDEF0, 1'b1, 3'd2, BURST_FIXED, RESP_OKAY,   32'h9ABC0000};

    s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = 3'd2; s_axi.awburst = BURST_INCR;
    s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
    s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; dbg_addr = '0;
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_awready", s_axi.awready, 1);
    check("rst_wready", s_axi.wready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_bresp", s_axi.bresp, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    ARESETN = 1'b1;

    // Zero-fill the whole memory with four 256-beat INCR bursts.
    for (int b = 0; b < 256; b++) begin
      beat_data[b] = '0; beat_strb[b] = 4'hF; beat_last[b] = (b == 255);
    end
    for (int i = 0; i < 4; i++) begin
      exp = model_burst(32'(i * 1024), 8'd255, 3'd2, BURST_INCR);
      run_burst(32'(i * 1024), 8'd255, 3'd2, BURST_INCR, 0, 0, exp, "fill");
    end

    // Minimum latency: AW at N, W at N+1, bvalid at N+2; early W must stall.
    @(negedge ACLK);
    s_axi.awaddr = 32'h10; s_axi.awlen = 8'd0; s_axi.awsize = 3'd2; s_axi.awburst = BURST_INCR;
    s_axi.awvalid = 1'b1;
    s_axi.wdata = 32'hDEADBEEF; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
    check("lat_w_stalled", s_axi.wready, 0);
    @(negedge ACLK);
    s_axi.awvalid = 1'b0;
    check("lat_n1_wready", s_axi.wready, 1);
    check("lat_n1_bvalid", s_axi.bvalid, 0);
    @(negedge ACLK);
    s_axi.wvalid = 1'b0;
    check("lat_n2_bvalid", s_axi.bvalid, 1);
    check("lat_n2_bresp", s_axi.bresp, RESP_OKAY);
    check("lat_n2_wready", s_axi.wready, 0);
    s_axi.bready = 1'b1;
    @(negedge ACLK);
    s_axi.bready = 1'b0;
    check("lat_b_done", s_axi.bvalid, 0);
    beat_data[0] = 32'hDEADBEEF; beat_strb[0] = 4'hF; beat_last[0] = 1'b1;
    void'(model_burst(32'h10, 8'd0, 3'd2, BURST_INCR));
    dbg_check(32'h10 / 4, 32'hDEADBEEF, "lat_dbg_word");

    for (int i = 0; i < 10; i++) begin
      beat_data[0] = vecs[i].data; beat_strb[0] = vecs[i].strb; beat_last[0] = vecs[i].last;
      void'(model_burst(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst));
      run_burst(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, i % 3, 0, vecs[i].exp_resp,
                $sformatf("vec%0d", i));
      dbg_check(int'(vecs[i].addr >> 2), vecs[i].exp_word, $sformatf("vec%0d_word", i));
    end

    // INCR x4 with a slow BREADY
    for (int b = 0; b < 4; b++) begin
      beat_data[b] = 32'(b + 1); beat_strb[b] = 4'hF; beat_last[b] = (b == 3);
    end
    void'(model_burst(32'h100, 8'd3, 3'd2, BURST_INCR));
    run_burst(32'h100, 8'd3, 3'd2, BURST_INCR, 5, 0, RESP_OKAY, "incr4");
    for (int b = 0; b < 4; b++) dbg_check(32'h40 + b, 32'(b + 1), "incr4_word");

    // FIXED burst overwrites the same low byte
    beat_data[0] = 32'hAA; beat_strb[0] = 4'h1; beat_last[0] = 1'b0;
    beat_data[1] = 32'hBB; beat_strb[1] = 4'h1; beat_last[1] = 1'b1;
    void'(model_burst(32'h20, 8'd1, 3'd2, BURST_FIXED));
    run_burst(32'h20, 8'd1, 3'd2, BURST_FIXED, 0, 0, RESP_OKAY, "fixed2");
    dbg_check(32'h20 / 4, 32'h000000BB, "fixed2_word");

    // Early wlast: both beats land, response SLVERR
    beat_data[0] = 32'h111; beat_strb[0] = 4'hF; beat_last[0] = 1'b1;
    beat_data[1] = 32'h222; beat_strb[1] = 4'hF; beat_last[1] = 1'b0;
    void'(model_burst(32'h80, 8'd1, 3'd2, BURST_INCR));
    run_burst(32'h80, 8'd1, 3'd2, BURST_INCR, 1, 0, RESP_SLVERR, "early_last");
    dbg_check(32'h20, 32'h111, "early_last_w0");
    dbg_check(32'h21, 32'h222, "early_last_w1");

    // Reset pulse after two beats of a four-beat burst
    @(negedge ACLK);
    s_axi.awaddr = 32'h200; s_axi.awlen = 8'd3; s_axi.awsize = 3'd2; s_axi.awburst = BURST_INCR;
    s_axi.awvalid = 1'b1;
    @(negedge ACLK);
    s_axi.awvalid = 1'b0;
    check("rstmid_wready", s_axi.wready, 1);
    s_axi.wdata = 32'hA0A0A0A0; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
    @(negedge ACLK);
    s_axi.wdata = 32'hA1A1A1A1;
    @(negedge ACLK);
    s_axi.wvalid = 1'b0;
    #2 ARESETN = 1'b0;
    #1;
    check("rstmid_wready_low", s_axi.wready, 0);
    check("rstmid_bvalid_low", s_axi.bvalid, 0);
    check("rstmid_awready", s_axi.awready, 1);
    check("rstmid_bresp", s_axi.bresp, 0);
    check("rstmid_dbg", dbg_rdata, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    ref_mem[32'h80] = 32'hA0A0A0A0;
    ref_mem[32'h81] = 32'hA1A1A1A1;
    dbg_check(32'h80, 32'hA0A0A0A0, "rstmid_beat0");
    dbg_check(32'h81, 32'hA1A1A1A1, "rstmid_beat1");
    dbg_check(32'h82, ref_mem[32'h82], "rstmid_beat2_untouched");
    beat_data[0] = 32'h0C0C0C0C; beat_strb[0] = 4'hF; beat_last[0] = 1'b0;
    beat_data[1] = 32'h0D0D0D0D; beat_strb[1] = 4'hF; beat_last[1] = 1'b1;
    void'(model_burst(32'h300, 8'd1, 3'd2, BURST_INCR));
    run_burst(32'h300, 8'd1, 3'd2, BURST_INCR, 0, 0, RESP_OKAY, "post_rst");
    dbg_check(32'hC1, 32'h0D0D0D0D, "post_rst_word");

    // Address one memory size past the base
    beat_data[0] = 32'h5A5A5A5A; beat_strb[0] = 4'hF; beat_last[0] = 1'b1;
    exp = model_burst(32'(4 * MEM_DEPTH), 8'd0, 3'd2, BURST_INCR);
    run_burst(32'(4 * MEM_DEPTH), 8'd0, 3'd2, BURST_INCR, 0, 0, exp, "oob");
    dbg_check(0, ref_mem[0], "oob_word0");

    for (int t = 0; t < 40; t++) begin
      word = $urandom_range(0, MEM_DEPTH - 1);
      if ($urandom_range(0, 7) == 0) word += MEM_DEPTH * $urandom_range(1, 3);
      addr = 32'(word * 4);
      len  = 8'($urandom_range(0, 7));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      r = $urandom_range(0, 9);
      burst = (r == 0) ? 2'b10 : ((r == 1) ? 2'b11 : 2'(r % 2));
      for (int b = 0; b <= int'(len); b++) begin
        beat_data[b] = $urandom;
        beat_strb[b] = 4'($urandom_range(0, 15));
        beat_last[b] = (b == int'(len));
      end
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, int'(len));
        beat_last[r] = ~beat_last[r];
      end
      exp = model_burst(addr, len, size, burst);
      run_burst(addr, len, size, burst, $urandom_range(0, 3), 2, exp, $sformatf("rnd%0d", t));
      for (int b = 0; b <= int'(len); b++) begin
        r = (word + ((burst == BURST_INCR) ? b : 0)) % MEM_DEPTH;
        dbg_check(r, ref_mem[r], $sformatf("rnd%0d_word%0d", t, r));
      end
    end

    for (int w = 0; w < MEM_DEPTH; w++) dbg_check(w, ref_mem[w], $sformatf("sweep_word%0d", w));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
